// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU in reset until verified.
// Define BOOT_DMEM_CLEAR_EN to zero data memory after a good checksum.
module imem_boot_loader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_HDR, S_LOAD, S_CHK, S_CLR, S_DONE, S_ERR
   } state_t;

   localparam logic [DATA_W-1:0] MAX_N = DATA_W'(1) << ADDR_W;
   localparam logic [ADDR_W:0]   ONE_W = 1;

   state_t              r_state;
   state_t              w_next;
   logic                r_ready;
   logic [1:0]          r_bcnt;
   logic [23:0]         r_shift;
   logic [ADDR_W:0]     r_n;
   logic [ADDR_W:0]     r_wcnt;
   logic [DATA_W-1:0]   r_xor;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                w_xfer;
   logic                w_last;
   logic [DATA_W-1:0]   w_word;
   logic [ADDR_W:0]     w_wnext;
   logic                w_rdy_next;
   logic                w_dwe;
   logic                w_done;
   logic                w_err;

   assign w_xfer  = in_valid && r_ready;
   assign w_last  = w_xfer && (r_bcnt == 2'd3);
   assign w_word  = {r_shift, in_byte};
   assign w_wnext = r_wcnt + ONE_W;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_HDR;
      else        r_state <= w_next;
   end

`ifdef BOOT_DMEM_CLEAR_EN
   logic [ADDR_W-1:0] r_clr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 r_clr <= '0;
      else if (r_state == S_CLR)  r_clr <= r_clr + 1'b1;
   end
`endif

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_HDR: if (w_last) begin
            if (w_word == '0)       w_next = S_CHK;
            else if (w_word > MAX_N) w_next = S_ERR;
            else                    w_next = S_LOAD;
         end
         S_LOAD: if (w_last && (w_wnext == r_n)) w_next = S_CHK;
         S_CHK: if (w_last) begin
`ifdef BOOT_DMEM_CLEAR_EN
            w_next = (w_word == r_xor) ? S_CLR : S_ERR;
`else
            w_next = (w_word == r_xor) ? S_DONE : S_ERR;
`endif
         end
`ifdef BOOT_DMEM_CLEAR_EN
         S_CLR: if (&r_clr) w_next = S_DONE;
`endif
         default: w_next = r_state;
      endcase
   end

   always_comb begin
      w_rdy_next = (w_next == S_HDR) || (w_next == S_LOAD) ||
                   (w_next == S_CHK);
      w_dwe      = (r_state == S_CLR);
      w_done     = (r_state == S_DONE);
      w_err      = (r_state == S_ERR);
   end

   // Byte assembly, word writes and running checksum
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ready <= 1'b0;
         r_bcnt  <= '0;
         r_shift <= '0;
         r_n     <= '0;
         r_wcnt  <= '0;
         r_xor   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_ready <= w_rdy_next;
         r_we    <= 1'b0;
         if (w_xfer) begin
            r_bcnt  <= r_bcnt + 2'd1;
            r_shift <= w_word[23:0];
         end
         if (w_last && r_state == S_HDR)
            r_n <= w_word[ADDR_W:0];
         if (w_last && r_state == S_LOAD) begin
            r_we    <= 1'b1;
            r_addr  <= r_wcnt[ADDR_W-1:0];
            r_wdata <= w_word;
            r_wcnt  <= w_wnext;
            r_xor   <= r_xor ^ w_word;
         end
      end
   end

   assign in_ready   = r_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign done       = w_done;
   assign cpu_reset  = w_done;
   assign error      = w_err;
`ifdef BOOT_DMEM_CLEAR_EN
   assign dmem_we    = w_dwe;
   assign dmem_addr  = r_clr;
`else
   assign dmem_we    = 1'b0;
   assign dmem_addr  = '0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frame table plus reset and sweep sequences.
// Honors BOOT_DMEM_CLEAR_EN when the design is built with it.
module tb_imem_boot_loader;

   localparam int AW = 12;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_byte = 8'h00;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          dmem_we;
   logic [AW-1:0] dmem_addr;
   logic          cpu_reset;
   logic          done;
   logic          error;

   always #5 clock = ~clock;

   imem_boot_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_byte    (in_byte),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   typedef struct {
      string             name;
      logic [31:0]       n;
      int                nw;
      logic [15:0][31:0] w;
      logic [31:0]       cd;
      bit                body;
      bit                stall;
      bit                err;
      bit                dn;
   } vec_t;

   vec_t        vecs[7];
   logic [43:0] wq[$];
   logic [43:0] full_q[$];
   bit          dmem_seen = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(negedge clock) begin
      if (imem_we) wq.push_back({imem_addr, imem_wdata});
      if (dmem_we) dmem_seen = 1'b1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic [31:0] n,
                               input int nw, input logic [31:0] cd,
                               input bit body, input bit stall,
                               input bit err, input bit dn);
      vec_t v;
      v.name = nm;  v.n = n;  v.nw = nw;  v.w = '0;  v.cd = cd;
      v.body = body; v.stall = stall; v.err = err; v.dn = dn;
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit stall);
      bit ok;
      ok = 1'b0;
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clock);
      in_valid = 1'b1;
      in_byte  = b;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(posedge clock);
         ok = in_ready;
         @(negedge clock);
      end
      in_valid = 1'b0;
      if (!ok) chk("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit stall);
      for (int j = 3; j >= 0; j--) send_byte(w[j*8 +: 8], stall);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      chk("reset_values",
          64'({in_ready, imem_we, imem_addr, imem_wdata, dmem_we,
               dmem_addr, cpu_reset, done, error}), 64'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("ready_after_reset", 64'(in_ready), 64'd1);
      wq.delete();
   endtask

   task automatic wait_clear();
`ifdef BOOT_DMEM_CLEAR_EN
      repeat (4096) @(negedge clock);
`endif
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        v;
      logic [31:0] x;
      int          exp_wr;
      int          bad;

      vecs[0] = mk("basic",     32'd2,      2,  32'd0, 1, 0, 0, 1);
      vecs[0].w[0] = 32'h2010_0009;
      vecs[0].w[1] = 32'h0000_0000;
      vecs[1] = vecs[0];
      vecs[1].name = "bad_csum";
      vecs[1].cd = 32'd1;
      vecs[1].err = 1'b1;
      vecs[1].dn = 1'b0;
      vecs[2] = mk("oversize",  32'h1001,   0,  32'd0, 0, 0, 1, 0);
      vecs[3] = mk("max_hdr",   32'h1000,   0,  32'd0, 0, 0, 0, 0);
      vecs[4] = mk("empty",     32'd0,      0,  32'd0, 1, 0, 0, 1);
      vecs[5] = mk("w16_full",  32'd16,     16, 32'd0, 1, 0, 0, 1);
      for (int i = 0; i < 16; i++)
         vecs[5].w[i] = 32'h1357_9BDF ^ (32'(i) * 32'h0102_0305);
      vecs[6] = vecs[5];
      vecs[6].name = "w16_stall";
      vecs[6].stall = 1'b1;

      for (int t = 0; t < 7; t++) begin
         v = vecs[t];
         x = 32'd0;
         do_reset();
         send_word(v.n, v.stall);
         if (v.body) begin
            for (int i = 0; i < v.nw; i++) begin
               send_word(v.w[i], v.stall);
               chk({v.name, "_wr_latency"},
                   64'({imem_we, imem_addr, imem_wdata}),
                   64'({1'b1, 12'(i), v.w[i]}));
               x = x ^ v.w[i];
            end
            send_word(x ^ v.cd, v.stall);
         end
         if (v.dn) wait_clear();
         chk({v.name, "_status"},
             64'({done, cpu_reset, error, in_ready}),
             64'({v.dn, v.dn, v.err, !(v.dn || v.err)}));
         if (v.dn || v.err) begin
            in_valid = 1'b1;
            repeat (8) begin
               in_byte = 8'($urandom);
               @(negedge clock);
            end
            in_valid = 1'b0;
            chk({v.name, "_sticky"},
                64'({done, cpu_reset, error, in_ready}),
                64'({v.dn, v.dn, v.err, 1'b0}));
         end
         exp_wr = v.body ? v.nw : 0;
         chk({v.name, "_wr_count"}, 64'(wq.size()), 64'(exp_wr));
         for (int i = 0; i < wq.size() && i < exp_wr; i++)
            chk({v.name, "_wr_entry"}, 64'(wq[i]),
                64'({12'(i), v.w[i]}));
         if (t == 5) full_q = wq;
         if (t == 6) begin
            bad = (wq.size() == full_q.size()) ? 0 : 1;
            for (int i = 0; i < wq.size() && i < full_q.size(); i++)
               if (wq[i] !== full_q[i]) bad++;
            chk("stall_vs_full", 64'(bad), 64'd0);
         end
      end

      // Reset in the middle of word 5, then a fresh one-word frame
      do_reset();
      send_word(32'd8, 1'b0);
      for (int i = 0; i < 5; i++) send_word(32'h100 + 32'(i), 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      chk("midword_pre_writes", 64'(wq.size()), 64'd5);
      reset = 1'b0;
      #1;
      chk("async_reset",
          64'({in_ready, imem_we, cpu_reset, done, error}), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      wq.delete();
      @(negedge clock);
      chk("midword_ready", 64'(in_ready), 64'd1);
      send_word(32'd1, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      wait_clear();
      chk("midword_done", 64'({done, cpu_reset, error}), 64'b110);
      chk("midword_wr_count", 64'(wq.size()), 64'd1);
      if (wq.size() > 0)
         chk("midword_wr_entry", 64'(wq[0]), 64'({12'd0, 32'hDEAD_BEEF}));

`ifdef BOOT_DMEM_CLEAR_EN
      do_reset();
      send_word(32'd1, 1'b0);
      send_word(32'hCAFE_F00D, 1'b0);
      send_word(32'hCAFE_F00D, 1'b0);
      bad = 0;
      for (int k = 0; k < 4096; k++) begin
         if (!(dmem_we && dmem_addr == 12'(k) && !cpu_reset && !done))
            bad++;
         @(negedge clock);
      end
      chk("clear_sweep", 64'(bad), 64'd0);
      chk("clear_end", 64'({dmem_we, cpu_reset, done}), 64'b011);
`else
      chk("no_dmem_we", 64'(dmem_seen), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream program loader that sits directly upstream of the CPU's instruction memory. It replaces the simulation-only preload of the instruction memory and the zeroing of data memory with synthesizable hardware. After reset it receives a framed program over a valid/ready byte interface, writes the 32-bit words into instruction memory, and verifies a checksum. It holds the CPU in reset until the image is loaded and accepted.

## Interface
- ADDR_W, 12, word-address width of instruction/data memory (capacity 2^ADDR_W = 4096 words)
- DATA_W, 32, memory word width; fixed at 32, the byte assembly assumes 4 bytes per word

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  byte available on in_byte
- in_byte  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  instruction-memory word address
- imem_wdata  out  DATA_W  instruction word
- dmem_we  out  1  data-memory write strobe (clear sweep only)
- dmem_addr  out  ADDR_W  data-memory word address
- cpu_reset  out  1  active-low reset to CPU; low until load succeeds
- done  out  1  image loaded and verified
- error  out  1  framing or checksum failure; sticky until reset

## Operation
- Frame layout, big-endian, first byte = MSB: 4-byte word count N, N 4-byte payload words, 4-byte checksum (XOR of all N payload words; equals 0 when N=0).
- A byte transfers on a rising edge with in_valid && in_ready. Transfers are the only way state advances in HDR/LOAD/CHK.
- States:
  - HDR: collect 4 bytes into N. If N=0, go to CHK. If N > 2^ADDR_W, go to ERR. Otherwise go to LOAD.
  - LOAD: collect 4 bytes per word. On the 4th byte, register a write: imem_we=1, imem_addr=word index (0,1,2…), imem_wdata=word. Update the running XOR. After word N-1, go to CHK.
  - CHK: collect 4 bytes. On a match, go to CLR if BOOT_DMEM_CLEAR_EN is defined, else to DONE. On a mismatch, go to ERR.
  - CLR: dmem_we=1 with dmem_addr stepping 0 to 2^ADDR_W-1, one address per cycle. The write data is zero by construction (the data-memory mux selects zero while dmem_we from the loader is active). Go to DONE after the last address.
  - DONE: terminal state. cpu_reset=1, done=1, in_ready=0. Bytes are ignored.
  - ERR: terminal state. error=1, cpu_reset=0, in_ready=0.
- in_ready=1 exactly in HDR, LOAD and CHK.
- The byte counter, word counter and XOR accumulator are cleared on entry to HDR. The word counter is ADDR_W+1 bits wide so that N = 2^ADDR_W does not wrap.
- Reset asserted at any point, mid-word or mid-sweep, returns to HDR and discards partial bytes. Memory contents already written are not restored.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, dmem_we=0, dmem_addr=0, cpu_reset=0, done=0, error=0, state=HDR.
- in_ready is registered. It rises on the first clock edge after reset deasserts.
- Write latency: imem_we is high in the cycle after the edge that accepts the 4th byte of a word. Address and data are stable for that cycle. Back-to-back full-rate input gives one write every 4 cycles.
- The state change after the final checksum byte is visible on the next edge. cpu_reset and done rise together in the same cycle and never fall before reset.
- CLR sweep takes exactly 2^ADDR_W cycles (4096 by default). DONE is entered on the edge after the last dmem_we cycle.
- in_valid may be deasserted between any bytes. Gaps stall progress with no loss and no timeout.

## Configuration
- BOOT_DMEM_CLEAR_EN defined: the CLR state exists. Data memory is zeroed after a successful checksum and before cpu_reset releases.
- BOOT_DMEM_CLEAR_EN undefined: CHK success goes straight to DONE. dmem_we is tied 0 and dmem_addr is tied 0.

## Test plan
- Basic load: N=2, words 0x20100009 and 0x00000000, checksum 0x20100009, sent at full rate. Expect imem writes (0,0x20100009) then (1,0x00000000). Expect done=1 and cpu_reset=1 on the cycle after the last checksum byte (clear disabled).
- Bad checksum: same frame with checksum 0x20100008. Expect error=1, cpu_reset=0, in_ready=0. Further bytes cause no writes.
- Oversize and empty: N=0x00001001 gives error right after the header. N=0 with checksum 0 gives done with no imem_we.
- Stalls: in_valid toggled randomly for a 16-word frame. Expect write sequence and addresses identical to the full-rate run.
- Reset mid-word: reset asserted after 2 bytes of word 5, then a new N=1 frame with word 0xDEADBEEF. Expect a single write at address 0, then done.
- Clear sweep (BOOT_DMEM_CLEAR_EN defined): after a valid N=1 frame, expect 4096 consecutive dmem_we cycles at addresses 0..4095. cpu_reset must stay 0 throughout and rise on the following cycle.
